// File: rtl/seq_lock_ctrl.sv
// Serial code lock: samples a 4-bit key every DIV cycles, compares it against PATTERN and
// counts consecutive mismatches. Define SEQ_LOCK_LOCKOUT_EN to compile in the timed LOCKOUT state.
module seq_lock_ctrl #(
    parameter int          DIV      = 4,
    parameter logic [3:0]  PATTERN  = 4'b1101,
    parameter int          MAX_FAIL = 3,
    parameter int          LOCK_CYC = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       key,
    output logic       pulse_p,
    output logic       busy,
    output logic       unlock,
    output logic       fail,
    output logic       locked,
    output logic [1:0] fail_cnt
);

    localparam int PW = $clog2(DIV);
    localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);
    localparam logic [1:0]    FAIL_SAT   = 2'(MAX_FAIL);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SAMPLE  = 2'd1,
        CHECK   = 2'd2,
        LOCKOUT = 2'd3
    } state_t;

    state_t          state_reg, state_next;
    logic [PW-1:0]   presc_reg, presc_next;
    logic [1:0]      bit_cnt_reg, bit_cnt_next;
    logic [3:0]      shreg_reg, shreg_next;
    logic [1:0]      fail_cnt_reg, fail_cnt_next;
    logic            unlock_reg, unlock_next;
    logic            fail_reg, fail_next;
    logic            strobe;
    logic [1:0]      fail_cnt_inc;

`ifdef SEQ_LOCK_LOCKOUT_EN
    localparam int LW = (LOCK_CYC > 1) ? $clog2(LOCK_CYC) : 1;
    logic [LW-1:0]   lock_cnt_reg, lock_cnt_next;
`endif

    assign strobe       = (state_reg == SAMPLE) && (presc_reg == PRESC_LAST);
    assign fail_cnt_inc = (fail_cnt_reg >= FAIL_SAT) ? FAIL_SAT : fail_cnt_reg + 2'd1;

    // Outputs are forced low while rst is held, not just from the first reset edge on.
    assign pulse_p  = strobe & ~rst;
    assign busy     = (state_reg != IDLE) & ~rst;
    assign unlock   = unlock_reg & ~rst;
    assign fail     = fail_reg & ~rst;
    assign locked   = (state_reg == LOCKOUT) & ~rst;
    assign fail_cnt = fail_cnt_reg & {2{~rst}};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            presc_reg    <= '0;
            bit_cnt_reg  <= '0;
            shreg_reg    <= '0;
            fail_cnt_reg <= '0;
            unlock_reg   <= 1'b0;
            fail_reg     <= 1'b0;
`ifdef SEQ_LOCK_LOCKOUT_EN
            lock_cnt_reg <= '0;
`endif
        end else begin
            state_reg    <= state_next;
            presc_reg    <= presc_next;
            bit_cnt_reg  <= bit_cnt_next;
            shreg_reg    <= shreg_next;
            fail_cnt_reg <= fail_cnt_next;
            unlock_reg   <= unlock_next;
            fail_reg     <= fail_next;
`ifdef SEQ_LOCK_LOCKOUT_EN
            lock_cnt_reg <= lock_cnt_next;
`endif
        end
    end

    always_comb begin
        state_next    = state_reg;
        presc_next    = presc_reg;
        bit_cnt_next  = bit_cnt_reg;
        shreg_next    = shreg_reg;
        fail_cnt_next = fail_cnt_reg;
        unlock_next   = 1'b0;
        fail_next     = 1'b0;
`ifdef SEQ_LOCK_LOCKOUT_EN
        lock_cnt_next = lock_cnt_reg;
`endif
        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next   = SAMPLE;
                    presc_next   = '0;
                    bit_cnt_next = '0;
                    shreg_next   = '0;
                end
            end
            SAMPLE: begin
                if (strobe) begin
                    presc_next   = '0;
                    shreg_next   = {shreg_reg[2:0], key};
                    bit_cnt_next = bit_cnt_reg + 2'd1;
                    if (bit_cnt_reg == 2'd3) begin
                        state_next = CHECK;
                    end
                end else begin
                    presc_next = presc_reg + 1'b1;
                end
            end
            CHECK: begin
                if (shreg_reg == PATTERN) begin
                    unlock_next   = 1'b1;
                    fail_cnt_next = 2'd0;
                    state_next    = IDLE;
                end else begin
                    fail_next     = 1'b1;
                    fail_cnt_next = fail_cnt_inc;
                    state_next    = IDLE;
`ifdef SEQ_LOCK_LOCKOUT_EN
                    if (fail_cnt_inc == FAIL_SAT) begin
                        state_next    = LOCKOUT;
                        lock_cnt_next = LW'(LOCK_CYC - 1);
                    end
`endif
                end
            end
            LOCKOUT: begin
`ifdef SEQ_LOCK_LOCKOUT_EN
                if (lock_cnt_reg == '0) begin
                    state_next    = IDLE;
                    fail_cnt_next = 2'd0;
                end else begin
                    lock_cnt_next = lock_cnt_reg - 1'b1;
                end
`else
                state_next = IDLE;
`endif
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: doc/seq_lock_ctrl.md
SEQ_LOCK_CTRL -- requirements
Module: seq_lock_ctrl

Interface
REQ-001 Parameter DIV, default 4: clock cycles per sample strobe; legal range is 2 or more.
REQ-002 Parameter PATTERN, default 4'b1101: code to match; bit 3 is the first bit sampled.
REQ-003 Parameter MAX_FAIL, default 3: consecutive mismatches that trigger lockout; legal range 1..3.
REQ-004 Parameter LOCK_CYC, default 16: lockout duration in clock cycles; legal range 1 or more.
REQ-005 clk  in  1  system clock; every register updates on its rising edge.
REQ-006 rst  in  1  reset; synchronous, active-high.
REQ-007 start  in  1  request to begin one 4-bit code attempt.
REQ-008 key  in  1  serial key level, sampled only on strobe cycles.
REQ-009 pulse_p  out  1  sample strobe issued to the detector datapath.
REQ-010 busy  out  1  high in every state except IDLE.
REQ-011 unlock  out  1  one-cycle pulse when an attempt matches.
REQ-012 fail  out  1  one-cycle pulse when an attempt mismatches.
REQ-013 locked  out  1  high while in LOCKOUT.
REQ-014 fail_cnt  out  2  consecutive mismatch count.

Function
REQ-015 The FSM SHALL have the states IDLE, SAMPLE, CHECK and LOCKOUT, encoded in 2 bits.
REQ-016 In IDLE with start=1, the block SHALL enter SAMPLE on the next edge and clear the prescaler, bit counter and shift register.
REQ-017 In SAMPLE, the prescaler SHALL count 0..DIV-1 and wrap to 0.
REQ-018 pulse_p SHALL be combinational: high only when state=SAMPLE and prescaler=DIV-1.
REQ-019 On each edge where pulse_p=1, the block SHALL execute shreg<={shreg[2:0],key} and increment the bit counter.
REQ-020 On the edge that captures the 4th bit, the block SHALL move from SAMPLE to CHECK.
REQ-021 CHECK SHALL last exactly one cycle, in which shreg is compared with PATTERN.
REQ-022 On a match, the block SHALL register unlock=1 for one cycle, clear fail_cnt and return to IDLE.
REQ-023 On a mismatch, the block SHALL register fail=1 for one cycle and increment fail_cnt, saturating at MAX_FAIL.
REQ-024 After a mismatch, the next state SHALL be LOCKOUT if the new fail_cnt equals MAX_FAIL, otherwise IDLE.
REQ-025 Latency: if start is sampled at edge E0, the strobes SHALL occur in the cycles ending at E0+DIV·k (k=1..4), and unlock or fail SHALL be high in the cycle from E0+4·DIV+1 to E0+4·DIV+2.
REQ-026 In LOCKOUT, a down-counter loaded with LOCK_CYC-1 SHALL decrement once per cycle.
REQ-027 When that counter reaches 0, the block SHALL return to IDLE and clear fail_cnt, so locked is high for exactly LOCK_CYC cycles.
REQ-028 start SHALL be ignored in every state other than IDLE, including a start that arrives in the same cycle as the CHECK result.
REQ-029 key changes between strobes SHALL have no effect on the result.
REQ-030 unlock and fail SHALL never be high in the same cycle.
REQ-031 pulse_p SHALL never be high outside SAMPLE.

Reset
REQ-032 When rst=1 at an edge, the block SHALL enter IDLE and clear all counters, shreg and fail_cnt.
REQ-033 While rst=1, pulse_p, busy, unlock, fail and locked SHALL all be 0 and fail_cnt SHALL be 0.
REQ-034 rst SHALL take priority over every other input.
REQ-035 An assertion of rst in SAMPLE, CHECK or LOCKOUT SHALL abort the operation with no unlock or fail pulse.

Configuration
REQ-036 With macro SEQ_LOCK_LOCKOUT_EN defined, LOCKOUT and the lockout counter SHALL be compiled in as described above.
REQ-037 Without SEQ_LOCK_LOCKOUT_EN, LOCKOUT SHALL be unreachable and every mismatch SHALL return to IDLE.
REQ-038 Without SEQ_LOCK_LOCKOUT_EN, locked SHALL be tied to 0 and fail_cnt SHALL saturate at MAX_FAIL until a match or reset clears it.

Verification
REQ-039 Bench scenario: assert rst for 2 cycles -> all outputs 0, then busy=0 in IDLE.
REQ-040 Bench scenario: DIV=4, start at E0, key bits 1,1,0,1 on the strobes -> pulse_p in cycles ending E4/E8/E12/E16, unlock=1 in the cycle E17-E18, fail_cnt=0, busy=0 after.
REQ-041 Bench scenario: key bits 1,0,0,1 -> fail=1 for one cycle and fail_cnt=1; three such attempts with the macro defined -> locked=1 for 16 cycles, then fail_cnt=0.
REQ-042 Bench scenario: pulse start during SAMPLE and during LOCKOUT -> no restart and strobe spacing unchanged.
REQ-043 Bench scenario: rst at E10 of an attempt -> IDLE at E11 with no unlock or fail pulse; a new attempt with 1,1,0,1 -> unlock.
REQ-044 Bench scenario: macro undefined, four mismatches -> fail_cnt stays at 3 and locked stays 0; a following match -> unlock and fail_cnt=0.
